// File: rtl/store_buffer_pkg.sv
// Shared sizing constants for the MEM-stage store buffer.
// Contents:
//   SB_DEPTH - number of buffered stores (power of two, >= 2)
//   WORD_AW  - word-address width (byte address bits [31:2])
//   WORD_DW  - store data width
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;
  localparam int WORD_AW  = 30;
  localparam int WORD_DW  = 32;

endpackage

// File: rtl/store_buffer_sb_match.sv
// Age-ordered priority matcher for store-to-load forwarding.
// Walks the entries from oldest (rd index) to youngest, so a later match
// overrides an earlier one and the youngest matching store wins.
// Ports:
//   valid_i    - per-entry valid bits
//   addr_i     - per-entry word addresses
//   data_i     - per-entry store data
//   rd_idx_i   - slot index of the oldest entry
//   ld_addr_i  - load word address to search for
//   hit_o      - some valid entry matches ld_addr_i
//   data_o     - data of the youngest match, 0 when no match
module sb_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = WORD_AW,
  parameter int DW    = WORD_DW,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid_i,
  input  logic [AW-1:0]    addr_i [DEPTH],
  input  logic [DW-1:0]    data_i [DEPTH],
  input  logic [IW-1:0]    rd_idx_i,
  input  logic [AW-1:0]    ld_addr_i,
  output logic             hit_o,
  output logic [DW-1:0]    data_o
);

  logic [IW-1:0] idx_s;

  // Oldest-to-youngest scan; DEPTH is a power of two so the index add wraps.
  always_comb begin
    hit_o  = 1'b0;
    data_o = {DW{1'b0}};
    idx_s  = rd_idx_i;
    for (int k = 0; k < DEPTH; k++) begin
      idx_s = rd_idx_i + IW'(k);
      if (valid_i[idx_s] && (addr_i[idx_s] == ld_addr_i)) begin
        hit_o  = 1'b1;
        data_o = data_i[idx_s];
      end else begin
        hit_o  = hit_o;
        data_o = data_o;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// MEM-stage store buffer: FIFO of word stores drained to the D-cache, with
// store-to-load forwarding for younger loads.
// Ports:
//   clk_i, rst_i              - clock, async active-high reset
//   st_valid_i/addr_i/data_i  - store from the MEM stage
//   ld_valid_i/addr_i         - load from the MEM stage
//   ld_hit_o, ld_data_o       - forwarding result (youngest match)
//   sb_stall_o                - store could not be accepted this cycle
//   mem_write_o/addr_o/wdata_o- drain request carrying the head entry
//   mem_stall_i               - D-cache did not take the request
//   sb_empty_o                - buffer holds no stores
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = WORD_AW,
  parameter int DW    = WORD_DW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          st_valid_i,
  input  logic [AW-1:0] st_addr_i,
  input  logic [DW-1:0] st_data_i,
  input  logic          ld_valid_i,
  input  logic [AW-1:0] ld_addr_i,
  output logic          ld_hit_o,
  output logic [DW-1:0] ld_data_o,
  output logic          sb_stall_o,
  output logic          mem_write_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_stall_i,
  output logic          sb_empty_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];

  logic [IW-1:0] wr_idx_s, rd_idx_s;
  logic          empty_s, full_s, retire_s, accept_s;
  logic          match_hit_s;
  logic [DW-1:0] match_data_s;

  assign wr_idx_s = wr_ptr_q[IW-1:0];
  assign rd_idx_s = rd_ptr_q[IW-1:0];
  assign empty_s  = (wr_ptr_q == rd_ptr_q);
  // Same slot, opposite lap: every slot holds a pending store.
  assign full_s   = (wr_idx_s == rd_idx_s) && (wr_ptr_q[IW] != rd_ptr_q[IW]);

  assign mem_write_o = !empty_s;
  assign mem_addr_o  = addr_q[rd_idx_s];
  assign mem_wdata_o = data_q[rd_idx_s];
  assign sb_empty_o  = empty_s;

  assign retire_s   = mem_write_o && !mem_stall_i;
  // A retiring head frees a slot in the same cycle, so a full buffer still takes the store.
  assign accept_s   = st_valid_i && (!full_s || retire_s);
  assign sb_stall_o = st_valid_i && full_s && !retire_s;

  // Next pointers and valid bits; when full, retire and accept share a slot so accept is applied last.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    if (retire_s) begin
      rd_ptr_d           = rd_ptr_q + PW'(1);
      valid_d[rd_idx_s]  = 1'b0;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (accept_s) begin
      wr_ptr_d           = wr_ptr_q + PW'(1);
      valid_d[wr_idx_s]  = 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end

  // Pointer, valid and entry storage registers; reset discards all pending stores.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      valid_q  <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= {AW{1'b0}};
        data_q[i] <= {DW{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      if (accept_s) begin
        addr_q[wr_idx_s] <= st_addr_i;
        data_q[wr_idx_s] <= st_data_i;
      end
    end
  end

  sb_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW),
    .IW    (IW)
  ) u_match (
    .valid_i   (valid_q),
    .addr_i    (addr_q),
    .data_i    (data_q),
    .rd_idx_i  (rd_idx_s),
    .ld_addr_i (ld_addr_i),
    .hit_o     (match_hit_s),
    .data_o    (match_data_s)
  );

  // Forwarding result only counts for a load in flight; data is zeroed on a miss.
  assign ld_hit_o  = ld_valid_i && match_hit_s;
  assign ld_data_o = ld_hit_o ? match_data_s : {DW{1'b0}};

endmodule
